// File: rtl/mix_col_iter.sv
// Iterative AES MixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define MIX_COL_INV_EN to build InvMixColumns, selected per block by in_inv.
module mix_col_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    localparam int unsigned GW = 32 * COLS_PER_CYCLE;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [0:127] src;
    logic [0:GW-1] grp_src;
    logic [0:GW-1] grp_c;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row i: 2*a[i] ^ 3*a[i+1] ^ a[i+2] ^ a[i+3], indices mod 4
    function automatic logic [0:31] fwd_col(input logic [0:31] c);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [0:31] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[8*i +: 8];
            m2[i] = xtime(a[i]);
        end
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = m2[i] ^ m2[2'(i+1)] ^ a[2'(i+1)] ^ a[2'(i+2)] ^ a[2'(i+3)];
        end
        return r;
    endfunction

`ifdef MIX_COL_INV_EN
    logic inv_q;

    // Row i: 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]
    function automatic logic [0:31] inv_col(input logic [0:31] c);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [0:31] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[8*i +: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = (m8[i] ^ m4[i] ^ m2[i])
                        ^ (m8[2'(i+1)] ^ m2[2'(i+1)] ^ a[2'(i+1)])
                        ^ (m8[2'(i+2)] ^ m4[2'(i+2)] ^ a[2'(i+2)])
                        ^ (m8[2'(i+3)] ^ a[2'(i+3)]);
        end
        return r;
    endfunction
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    // Transform the column group selected by the counter
    always_comb begin
        grp_c   = '0;
        grp_src = src[{cnt, 5'b0} +: GW];
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef MIX_COL_INV_EN
            grp_c[32*j +: 32] = inv_q ? inv_col(grp_src[32*j +: 32])
                                      : fwd_col(grp_src[32*j +: 32]);
`else
            grp_c[32*j +: 32] = fwd_col(grp_src[32*j +: 32]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_state <= '0;
            cnt       <= '0;
            src       <= '0;
`ifdef MIX_COL_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src      <= in_state;
`ifdef MIX_COL_INV_EN
                        inv_q    <= in_inv;
`endif
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    out_state[{cnt, 5'b0} +: GW] <= grp_c;
                    cnt <= cnt + 2'(COLS_PER_CYCLE);
                    if (cnt == 2'(4 - COLS_PER_CYCLE)) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_col_iter.sv
// Bench for mix_col_iter: three instances (1, 2, 4 columns/cycle) driven in parallel,
// directed FIPS-197 vectors, backpressure, mid-block reset and a random scoreboard run.
module tb_mix_col_iter;

`ifdef MIX_COL_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [0:127] in_state;
    logic         in_inv;
    logic         out_ready;
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [0:127] out_state [3];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_col_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .in_state (in_state),
            .in_inv   (in_inv),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_state(out_state[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:127] din;
        logic         inv;
        logic [0:127] exp;
    } vec_t;

    vec_t         vecs [7];
    logic [0:127] sbq [3][$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of any xtime chain
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? (8'({x, 1'b0}) ^ 8'h1b) : 8'({x, 1'b0});
        end
        return p;
    endfunction

    function automatic logic [0:127] mix_ref(input logic [0:127] s, input logic inv);
        logic [0:127] r;
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [31:0]  cf;
        int           k;
        cf = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) a[rr] = s[32*c + 8*rr +: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    k = (j - rr + 4) % 4;
                    b = b ^ gf_mul(a[j], cf[8*(3-k) +: 8]);
                end
                r[32*c + 8*rr +: 8] = b;
            end
        end
        return r;
    endfunction

    // Apply one block to all instances, hold out_ready low for 'hold' cycles, then drain
    task automatic run_vec(input string tag, input logic [0:127] din, input logic inv,
                           input logic [0:127] exp, input int hold);
        int lat [3];
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_ready%0d", tag, i), 128'(in_ready[i]), 128'(1));
        in_valid  = 1'b1;
        in_state  = din;
        in_inv    = inv;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 0)
                for (int i = 0; i < 3; i++)
                    chk($sformatf("%s_busy%0d", tag, i), 128'({busy[i], in_ready[i]}), 128'(2'b10));
            for (int i = 0; i < 3; i++)
                if (out_valid[i] && lat[i] == 0) lat[i] = c;
            if (c > 4)
                for (int i = 0; i < 3; i++)
                    chk($sformatf("%s_hold%0d_c%0d", tag, i, c),
                        {out_valid[i], in_ready[i], out_state[i][0:125]},
                        {1'b1, 1'b0, exp[0:125]});
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_lat%0d", tag, i), 128'(lat[i]), 128'(4 >> i));
            chk($sformatf("%s_data%0d", tag, i), out_state[i], exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_idle%0d", tag, i), 128'({out_valid[i], in_ready[i], out_state[i] == exp}),
                128'(3'b011));
    endtask

    // Record handshakes that occur at the next rising edge
    task automatic sb_step();
        logic [0:127] e;
        for (int i = 0; i < 3; i++) begin
            if (out_valid[i] && out_ready) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("rand_extra%0d", i), 128'(sbq[i].size()), 128'(1));
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("rand_data%0d", i), out_state[i], e);
                end
            end
            if (in_valid && in_ready[i]) sbq[i].push_back(mix_ref(in_state, in_inv & INV_EN));
        end
    endtask

    initial begin
        int  acc_cnt;
        bit  acc0;

        vecs[0] = '{128'hdb135345_f20a225c_01010101_2d26314c, 1'b0,
                    128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8};
        vecs[1] = '{128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, 1'b1, 128'h0};
        vecs[1].exp = INV_EN ? 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5
                             : mix_ref(vecs[1].din, 1'b0);
        vecs[2] = '{128'h0, 1'b0, 128'h0};
        vecs[3] = '{{128{1'b1}}, 1'b1, {128{1'b1}}};
        vecs[4] = '{{16{8'hc6}}, 1'b1, {16{8'hc6}}};
        vecs[5] = '{128'hd4d4d4d5_c6c6c6c6_f20a225c_db135345, 1'b0,
                    128'hd5d5d7d6_c6c6c6c6_9fdc589d_8e4da1bc};
        vecs[6] = '{128'hd5d5d7d6_4d7ebdf8_01010101_9fdc589d, 1'b1, 128'h0};
        vecs[6].exp = INV_EN ? 128'hd4d4d4d5_2d26314c_01010101_f20a225c
                             : mix_ref(vecs[6].din, 1'b0);

        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset%0d", i), {out_state[i][0:124], in_ready[i], out_valid[i], busy[i]},
                {125'h0, 3'b100});
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_vec($sformatf("vec%0d", v), vecs[v].din, vecs[v].inv, vecs[v].exp, 6);

        // Long backpressure in DONE
        run_vec("bp", vecs[0].din, 1'b0, vecs[0].exp, 14);

        // Reset during the second BUSY cycle of the 1-column instance
        @(negedge clk);
        in_valid = 1'b1; in_state = vecs[5].din; in_inv = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("midrst%0d", i), {out_state[i][0:124], in_ready[i], out_valid[i], busy[i]},
                {125'h0, 3'b100});
        run_vec("after_rst", vecs[0].din, 1'b0, vecs[0].exp, 6);

        // Random traffic with a per-instance scoreboard
        acc_cnt = 0;
        acc0    = 1'b0;
        for (int cyc = 0; cyc < 40000 && acc_cnt < 1000; cyc++) begin
            @(negedge clk);
            if (!in_valid || acc0) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_inv   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc0 = in_valid && in_ready[0];
            if (acc0) acc_cnt++;
            sb_step();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 12; d++) begin
            sb_step();
            @(negedge clk);
        end
        chk("rand_count", 128'(acc_cnt), 128'(1000));
        for (int i = 0; i < 3; i++) chk($sformatf("rand_lost%0d", i), 128'(sbq[i].size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
